// File: rtl/hpdcache_mshr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hpdcache_mshr_ctrl                                              |
// | Function : Serialising single-port sequencer sharing the MSHR between the  |
// |            miss path (check-then-allocate) and the refill ack path.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module hpdcache_mshr_ctrl #(
  parameter int unsigned ACK_STREAK_MAX = 4,
  parameter int unsigned NLINE_WIDTH    = 26,
  parameter int unsigned MSHR_SETS      = 4,
  parameter int unsigned MSHR_WAYS      = 2,
  parameter int unsigned REQ_TID_WIDTH  = 6,
  parameter int unsigned REQ_SID_WIDTH  = 3,
  parameter int unsigned WORD_WIDTH     = 3,
  localparam int unsigned MSHR_SET_BITS  = (MSHR_SETS > 1) ? $clog2(MSHR_SETS) : 0,
  localparam int unsigned MSHR_SET_WIDTH = (MSHR_SETS > 1) ? MSHR_SET_BITS : 1,
  localparam int unsigned MSHR_WAY_WIDTH = (MSHR_WAYS > 1) ? $clog2(MSHR_WAYS) : 1,
  localparam int unsigned MSHR_TAG_WIDTH = NLINE_WIDTH - MSHR_SET_BITS
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      miss_valid_i,
  output logic                      miss_ready_o,
  input  logic [NLINE_WIDTH-1:0]    miss_nline_i,
  input  logic [REQ_TID_WIDTH-1:0]  miss_req_id_i,
  input  logic [REQ_SID_WIDTH-1:0]  miss_src_id_i,
  input  logic [WORD_WIDTH-1:0]     miss_word_i,
  input  logic                      miss_need_rsp_i,
  input  logic                      miss_is_prefetch_i,
  output logic                      miss_rsp_valid_o,
  output logic [1:0]                miss_rsp_status_o,
  output logic [MSHR_WAY_WIDTH-1:0] miss_rsp_way_o,

  input  logic                      ack_valid_i,
  output logic                      ack_ready_o,
  input  logic [MSHR_SET_WIDTH-1:0] ack_set_i,
  input  logic [MSHR_WAY_WIDTH-1:0] ack_way_i,
  output logic                      ack_rsp_valid_o,

  output logic                      mshr_check_o,
  output logic [MSHR_SET_WIDTH-1:0] mshr_check_set_o,
  output logic [MSHR_TAG_WIDTH-1:0] mshr_check_tag_o,
  input  logic                      mshr_hit_i,
  input  logic                      mshr_alloc_full_i,
  input  logic [MSHR_WAY_WIDTH-1:0] mshr_alloc_way_i,

  output logic                      mshr_alloc_o,
  output logic                      mshr_alloc_cs_o,
  output logic [NLINE_WIDTH-1:0]    mshr_alloc_nline_o,
  output logic [REQ_TID_WIDTH-1:0]  mshr_alloc_req_id_o,
  output logic [REQ_SID_WIDTH-1:0]  mshr_alloc_src_id_o,
  output logic [WORD_WIDTH-1:0]     mshr_alloc_word_o,
  output logic                      mshr_alloc_need_rsp_o,
  output logic                      mshr_alloc_is_prefetch_o,

  output logic                      mshr_ack_o,
  output logic                      mshr_ack_cs_o,
  output logic [MSHR_SET_WIDTH-1:0] mshr_ack_set_o,
  output logic [MSHR_WAY_WIDTH-1:0] mshr_ack_way_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CHK_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK_WAIT = 2'd2;

  localparam logic [1:0] RSP_ALLOC = 2'd0;
  localparam logic [1:0] RSP_HIT   = 2'd1;
  localparam logic [1:0] RSP_FULL  = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(ACK_STREAK_MAX);

  logic [1:0]                state_q, state_d;
  logic [3:0]                streak_q, streak_d;
  logic [NLINE_WIDTH-1:0]    nline_q, nline_d;
  logic [REQ_TID_WIDTH-1:0]  req_id_q, req_id_d;
  logic [REQ_SID_WIDTH-1:0]  src_id_q, src_id_d;
  logic [WORD_WIDTH-1:0]     word_q, word_d;
  logic                      need_rsp_q, need_rsp_d;
  logic                      is_prefetch_q, is_prefetch_d;

  logic                      idle;
  logic                      in_chk;
  logic                      ack_grant;
  logic                      miss_grant;
  logic                      chk_hit;
  logic                      chk_full;
  logic                      chk_alloc;
  logic [MSHR_SET_WIDTH-1:0] req_set;
  logic [MSHR_TAG_WIDTH-1:0] latched_tag;

  generate
    if (MSHR_SETS > 1) begin : g_split_sets
      assign req_set     = miss_nline_i[MSHR_SET_BITS-1:0];
      assign latched_tag = nline_q[MSHR_SET_BITS +: MSHR_TAG_WIDTH];
    end else begin : g_split_single
      assign req_set     = '0;
      assign latched_tag = nline_q[MSHR_TAG_WIDTH-1:0];
    end
  endgenerate

  // A cycle with reset asserted never grants or completes anything.
  assign idle   = (state_q == ST_IDLE) && !rst_i;
  assign in_chk = (state_q == ST_CHK_WAIT) && !rst_i;

  assign ack_grant  = idle && ack_valid_i && (!miss_valid_i || (streak_q < STREAK_MAX));
  assign miss_grant = idle && miss_valid_i && !ack_grant;

  assign chk_hit   = in_chk && mshr_hit_i;
  assign chk_full  = in_chk && !mshr_hit_i && mshr_alloc_full_i;
  assign chk_alloc = in_chk && !mshr_hit_i && !mshr_alloc_full_i;

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    nline_d       = nline_q;
    req_id_d      = req_id_q;
    src_id_d      = src_id_q;
    word_d        = word_q;
    need_rsp_d    = need_rsp_q;
    is_prefetch_d = is_prefetch_q;

    if (!miss_valid_i || miss_grant) begin
      streak_d = 4'd0;
    end else if (ack_grant && (streak_q != 4'hF)) begin
      streak_d = streak_q + 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ack_grant) begin
          state_d = ST_ACK_WAIT;
        end else if (miss_grant) begin
          state_d       = ST_CHK_WAIT;
          nline_d       = miss_nline_i;
          req_id_d      = miss_req_id_i;
          src_id_d      = miss_src_id_i;
          word_d        = miss_word_i;
          need_rsp_d    = miss_need_rsp_i;
          is_prefetch_d = miss_is_prefetch_i;
        end
      end
      ST_CHK_WAIT: state_d = ST_IDLE;
      ST_ACK_WAIT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      streak_q      <= 4'd0;
      nline_q       <= '0;
      req_id_q      <= '0;
      src_id_q      <= '0;
      word_q        <= '0;
      need_rsp_q    <= 1'b0;
      is_prefetch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      nline_q       <= nline_d;
      req_id_q      <= req_id_d;
      src_id_q      <= src_id_d;
      word_q        <= word_d;
      need_rsp_q    <= need_rsp_d;
      is_prefetch_q <= is_prefetch_d;
    end
  end

  assign miss_ready_o      = miss_grant;
  assign ack_ready_o       = ack_grant;

  assign mshr_check_o      = miss_grant;
  assign mshr_check_set_o  = miss_grant ? req_set : '0;
  assign mshr_check_tag_o  = in_chk ? latched_tag : '0;

  assign miss_rsp_valid_o  = in_chk;
  assign miss_rsp_status_o = chk_hit ? RSP_HIT : (chk_full ? RSP_FULL : RSP_ALLOC);
  assign miss_rsp_way_o    = chk_alloc ? mshr_alloc_way_i : '0;

  assign mshr_alloc_o             = chk_alloc;
  assign mshr_alloc_cs_o          = chk_alloc;
  assign mshr_alloc_nline_o       = chk_alloc ? nline_q : '0;
  assign mshr_alloc_req_id_o      = chk_alloc ? req_id_q : '0;
  assign mshr_alloc_src_id_o      = chk_alloc ? src_id_q : '0;
  assign mshr_alloc_word_o        = chk_alloc ? word_q : '0;
  assign mshr_alloc_need_rsp_o    = chk_alloc && need_rsp_q;
  assign mshr_alloc_is_prefetch_o = chk_alloc && is_prefetch_q;

  assign mshr_ack_o      = ack_grant;
  assign mshr_ack_cs_o   = ack_grant;
  assign mshr_ack_set_o  = ack_grant ? ack_set_i : '0;
  assign mshr_ack_way_o  = ack_grant ? ack_way_i : '0;
  assign ack_rsp_valid_o = (state_q == ST_ACK_WAIT) && !rst_i;

  a_one_ready : assert property (@(posedge clk_i) !(miss_ready_o && ack_ready_o));
  a_port_excl : assert property (@(posedge clk_i) !(mshr_ack_o && (mshr_check_o || mshr_alloc_o)));

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_mshr_ctrl.sv
`default_nettype none
// Scoreboard bench: miss results are queued when a request is driven and
// popped when the controller produces its response; a small MSHR model answers checks.
module tb_hpdcache_mshr_ctrl;

  localparam int NLINE_W = 26;
  localparam int SETS    = 4;
  localparam int WAYS    = 2;
  localparam int TID_W   = 6;
  localparam int SID_W   = 3;
  localparam int WORD_W  = 3;
  localparam int SET_W   = 2;
  localparam int WAY_W   = 1;
  localparam int TAG_W   = 24;

  localparam logic [1:0] S_ALLOC = 2'd0;
  localparam logic [1:0] S_HIT   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic               clk = 1'b0;
  logic               rst;
  logic               miss_valid, miss_ready;
  logic [NLINE_W-1:0] miss_nline;
  logic [TID_W-1:0]   miss_req_id;
  logic [SID_W-1:0]   miss_src_id;
  logic [WORD_W-1:0]  miss_word;
  logic               miss_need_rsp, miss_is_prefetch;
  logic               miss_rsp_valid;
  logic [1:0]         miss_rsp_status;
  logic [WAY_W-1:0]   miss_rsp_way;
  logic               ack_valid, ack_ready;
  logic [SET_W-1:0]   ack_set;
  logic [WAY_W-1:0]   ack_way;
  logic               ack_rsp_valid;
  logic               chk, chk_set_v;
  logic [SET_W-1:0]   chk_set;
  logic [TAG_W-1:0]   chk_tag;
  logic               m_hit, m_full;
  logic [WAY_W-1:0]   m_way;
  logic               alloc, alloc_cs;
  logic [NLINE_W-1:0] alloc_nline;
  logic [TID_W-1:0]   alloc_req_id;
  logic [SID_W-1:0]   alloc_src_id;
  logic [WORD_W-1:0]  alloc_word;
  logic               alloc_need_rsp, alloc_is_prefetch;
  logic               mack, mack_cs;
  logic [SET_W-1:0]   mack_set;
  logic [WAY_W-1:0]   mack_way;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]       status;
    logic [WAY_W-1:0] way;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hpdcache_mshr_ctrl #(.ACK_STREAK_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .miss_valid_i(miss_valid), .miss_ready_o(miss_ready), .miss_nline_i(miss_nline),
    .miss_req_id_i(miss_req_id), .miss_src_id_i(miss_src_id), .miss_word_i(miss_word),
    .miss_need_rsp_i(miss_need_rsp), .miss_is_prefetch_i(miss_is_prefetch),
    .miss_rsp_valid_o(miss_rsp_valid), .miss_rsp_status_o(miss_rsp_status), .miss_rsp_way_o(miss_rsp_way),
    .ack_valid_i(ack_valid), .ack_ready_o(ack_ready), .ack_set_i(ack_set), .ack_way_i(ack_way),
    .ack_rsp_valid_o(ack_rsp_valid),
    .mshr_check_o(chk), .mshr_check_set_o(chk_set), .mshr_check_tag_o(chk_tag),
    .mshr_hit_i(m_hit), .mshr_alloc_full_i(m_full), .mshr_alloc_way_i(m_way),
    .mshr_alloc_o(alloc), .mshr_alloc_cs_o(alloc_cs), .mshr_alloc_nline_o(alloc_nline),
    .mshr_alloc_req_id_o(alloc_req_id), .mshr_alloc_src_id_o(alloc_src_id), .mshr_alloc_word_o(alloc_word),
    .mshr_alloc_need_rsp_o(alloc_need_rsp), .mshr_alloc_is_prefetch_o(alloc_is_prefetch),
    .mshr_ack_o(mack), .mshr_ack_cs_o(mack_cs), .mshr_ack_set_o(mack_set), .mshr_ack_way_o(mack_way)
  );

  // MSHR model: lowest free way is allocated, check answers in the cycle after the check pulse.
  logic             mv   [SETS][WAYS];
  logic [TAG_W-1:0] mtag [SETS][WAYS];
  logic [TID_W-1:0] mtid [SETS][WAYS];
  logic [SET_W-1:0] chk_set_r;

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          mv[s][w]   <= 1'b0;
          mtag[s][w] <= '0;
          mtid[s][w] <= '0;
        end
      chk_set_r <= '0;
    end else begin
      if (chk) chk_set_r <= chk_set;
      if (alloc) begin
        mv[alloc_nline[1:0]][m_way]   <= 1'b1;
        mtag[alloc_nline[1:0]][m_way] <= alloc_nline[NLINE_W-1:2];
        mtid[alloc_nline[1:0]][m_way] <= alloc_req_id;
      end
      if (mack) mv[mack_set][mack_way] <= 1'b0;
    end
  end

  always_comb begin
    m_hit  = 1'b0;
    m_full = 1'b1;
    m_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!mv[chk_set_r][w]) begin
        m_full = 1'b0;
        m_way  = WAY_W'(w);
      end
      if (mv[chk_set_r][w] && (mtag[chk_set_r][w] == chk_tag)) m_hit = 1'b1;
    end
  end

  assign chk_set_v = |{miss_ready, ack_ready, miss_rsp_valid, miss_rsp_status, miss_rsp_way,
                       ack_rsp_valid, chk, chk_set, chk_tag, alloc, alloc_cs, alloc_nline,
                       alloc_req_id, alloc_src_id, alloc_word, alloc_need_rsp, alloc_is_prefetch,
                       mack, mack_cs, mack_set, mack_way};

  // Drives one miss, waits for acceptance, then checks the queued response one cycle later.
  task automatic do_miss(input logic [NLINE_W-1:0] nline, input logic [TID_W-1:0] tid,
                         input logic [1:0] st, input logic [WAY_W-1:0] way);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    miss_valid = 1'b1; miss_nline = nline; miss_req_id = tid;
    miss_src_id = 3'd5; miss_word = 3'd2; miss_need_rsp = 1'b1; miss_is_prefetch = 1'b0;
    exp_q.push_back('{status: st, way: way});
    #1;
    while (!miss_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (!(miss_ready && chk && chk_set == nline[1:0])) begin
      errors++;
      $display("FAIL miss_accept nline=%0h: ready=%0b check=%0b set=%0d, required 1/1/%0d",
               nline, miss_ready, chk, chk_set, nline[1:0]);
    end
    @(negedge clk);
    miss_valid = 1'b0;
    #1;
    checks++;
    if (!miss_rsp_valid || exp_q.size() == 0) begin
      errors++;
      $display("FAIL miss_rsp_valid nline=%0h: got %0b, required 1", nline, miss_rsp_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (miss_rsp_status !== e.status || (e.status == S_ALLOC && miss_rsp_way !== e.way)) begin
        errors++;
        $display("FAIL miss_rsp nline=%0h: status=%0d way=%0d, required status=%0d way=%0d",
                 nline, miss_rsp_status, miss_rsp_way, e.status, e.way);
      end
      checks++;
      if (alloc !== (e.status == S_ALLOC) ||
          (e.status == S_ALLOC && (alloc_nline !== nline || alloc_req_id !== tid || !alloc_cs))) begin
        errors++;
        $display("FAIL alloc_port nline=%0h: alloc=%0b nline=%0h id=%0h, required alloc=%0b nline=%0h id=%0h",
                 nline, alloc, alloc_nline, alloc_req_id, e.status == S_ALLOC, nline, tid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; miss_valid = 1'b0; ack_valid = 1'b0;
    miss_nline = '0; miss_req_id = '0; miss_src_id = '0; miss_word = '0;
    miss_need_rsp = 1'b0; miss_is_prefetch = 1'b0; ack_set = '0; ack_way = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (chk_set_v !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: some output high=%0b, required 0", chk_set_v);
    end
    @(negedge clk);
    ack_valid = 1'b1; ack_set = 2'd0; ack_way = 1'b0;
    #1;
    checks++;
    if (!(ack_ready && mack && mack_cs && !miss_ready)) begin
      errors++;
      $display("FAIL reset_ack_grant: ack_ready=%0b mshr_ack=%0b, required 1/1", ack_ready, mack);
    end
    @(negedge clk);
    ack_valid = 1'b0;
    #1;
    checks++;
    if (!(ack_rsp_valid && !ack_ready && !mack)) begin
      errors++;
      $display("FAIL reset_ack_rsp: ack_rsp_valid=%0b, required 1", ack_rsp_valid);
    end
  endtask

  task automatic test_alloc_hit();
    do_miss(26'h1234, 6'd1, S_ALLOC, 1'b0);
    do_miss(26'h1234, 6'd2, S_HIT, 1'b0);
  endtask

  task automatic test_full();
    do_miss(26'h0001, 6'd3, S_ALLOC, 1'b0);
    do_miss(26'h0005, 6'd4, S_ALLOC, 1'b1);
    do_miss(26'h0009, 6'd5, S_FULL, 1'b0);
  endtask

  task automatic test_ack_release();
    do_miss(26'h0002, 6'd6, S_ALLOC, 1'b0);
    do_miss(26'h0006, 6'h15, S_ALLOC, 1'b1);
    @(negedge clk);
    ack_valid = 1'b1; ack_set = 2'd2; ack_way = 1'b1;
    #1;
    checks++;
    if (!(ack_ready && mack && mack_set == 2'd2 && mack_way == 1'b1 && !chk && !alloc)) begin
      errors++;
      $display("FAIL ack_port: ready=%0b ack=%0b set=%0d way=%0d, required 1/1/2/1",
               ack_ready, mack, mack_set, mack_way);
    end
    checks++;
    if (mtid[2][1] !== 6'h15 || mtag[2][1] !== 24'd1) begin
      errors++;
      $display("FAIL ack_entry: id=%0h tag=%0h, required 15/1", mtid[2][1], mtag[2][1]);
    end
    @(negedge clk);
    ack_valid = 1'b0;
    #1;
    checks++;
    if (!(ack_rsp_valid && !mack)) begin
      errors++;
      $display("FAIL ack_rsp: ack_rsp_valid=%0b mshr_ack=%0b, required 1/0", ack_rsp_valid, mack);
    end
    do_miss(26'h000A, 6'd8, S_ALLOC, 1'b1);
  endtask

  task automatic test_streak();
    exp_t       e;
    logic [9:0] miss_mask = '0;
    int         grants = 0;
    @(negedge clk);
    miss_valid = 1'b1; miss_nline = 26'h0003; miss_req_id = 6'd9;
    ack_valid = 1'b1; ack_set = 2'd3; ack_way = 1'b1;
    exp_q.push_back('{status: S_ALLOC, way: 1'b0});
    exp_q.push_back('{status: S_HIT, way: 1'b0});
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (ack_ready && grants < 10) grants++;
      if (miss_ready && grants < 10) begin
        miss_mask[grants] = 1'b1;
        grants++;
      end
      if (miss_rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL streak_rsp: unexpected response status=%0d", miss_rsp_status);
        end else begin
          e = exp_q.pop_front();
          if (miss_rsp_status !== e.status || (e.status == S_ALLOC && miss_rsp_way !== e.way)) begin
            errors++;
            $display("FAIL streak_rsp: status=%0d way=%0d, required status=%0d way=%0d",
                     miss_rsp_status, miss_rsp_way, e.status, e.way);
          end
        end
      end
    end
    @(negedge clk);
    miss_valid = 1'b0; ack_valid = 1'b0;
    checks++;
    if (grants != 10 || miss_mask !== 10'b10_0001_0000) begin
      errors++;
      $display("FAIL streak_order: grants=%0d miss_mask=%b, required 10 and 1000010000", grants, miss_mask);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL streak_drain: %0d responses missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_chk();
    @(negedge clk);
    miss_valid = 1'b1; miss_nline = 26'h0007; miss_req_id = 6'd11;
    #1;
    checks++;
    if (!miss_ready) begin
      errors++; $display("FAIL rstchk_accept: ready=%0b, required 1", miss_ready);
    end
    @(negedge clk);
    miss_valid = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if (alloc || miss_rsp_valid) begin
      errors++;
      $display("FAIL rstchk_quiet: alloc=%0b rsp=%0b, required 0/0", alloc, miss_rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (chk_set_v !== 1'b0) begin
      errors++; $display("FAIL rstchk_outputs: some output high=%0b, required 0", chk_set_v);
    end
    // The model was cleared by reset too, so the lost request allocates way 0 afresh.
    do_miss(26'h0007, 6'd12, S_ALLOC, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alloc_hit();
    test_full();
    test_ack_release();
    test_streak();
    test_reset_chk();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hpdcache_mshr_ctrl.md
Name: hpdcache_mshr_ctrl

Overview:
- Single-port sequencer in front of hpdcache_mshr.
- Shares the MSHR between two requesters: the miss path (check-then-allocate) and the refill path (ack/release).
- Never issues an ack in the same cycle as a check or alloc.
- Serialises all operations, applies bounded-starvation arbitration, and returns one result per request.

Parameters:
- ACK_STREAK_MAX, 4: maximum consecutive ack grants while a miss request is pending. Range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- miss_valid_i  in  1  miss request valid; held stable until accepted
- miss_ready_o  out  1  miss request accepted this cycle
- miss_nline_i  in  hpdcache_nline_t  missing line
- miss_req_id_i  in  hpdcache_req_tid_t  transaction id
- miss_src_id_i  in  hpdcache_req_sid_t  source id
- miss_word_i  in  hpdcache_word_t  word index
- miss_need_rsp_i  in  1  response needed
- miss_is_prefetch_i  in  1  prefetch
- miss_rsp_valid_o  out  1  miss result pulse
- miss_rsp_status_o  out  2  0 = ALLOC, 1 = HIT, 2 = FULL
- miss_rsp_way_o  out  mshr_way_t  allocated way (meaningful for ALLOC only)
- ack_valid_i  in  1  refill release request
- ack_ready_o  out  1  ack request accepted this cycle
- ack_set_i  in  mshr_set_t  entry set
- ack_way_i  in  mshr_way_t  entry way
- ack_rsp_valid_o  out  1  released entry data pulse
- mshr_check_o, mshr_check_set_o, mshr_check_tag_o  out  1 / mshr_set_t / mshr_tag_t  to MSHR check port
- mshr_hit_i  in  1  from MSHR
- mshr_alloc_full_i  in  1  from MSHR
- mshr_alloc_way_i  in  mshr_way_t  from MSHR
- mshr_alloc_o, mshr_alloc_cs_o  out  1  to MSHR alloc port
- mshr_alloc_nline_o, _req_id_o, _src_id_o, _word_o, _need_rsp_o, _is_prefetch_o  out  typed  to MSHR alloc fields
- mshr_ack_o, mshr_ack_cs_o  out  1  to MSHR ack port
- mshr_ack_set_o  out  mshr_set_t  to MSHR
- mshr_ack_way_o  out  mshr_way_t  to MSHR

Behaviour:

States:
- IDLE, CHK_WAIT, ACK_WAIT.
- Reset (rst_i sampled high at clk_i edge) forces IDLE and clears the streak counter and all latched fields.
- After reset, all outputs are 0 except miss_ready_o and ack_ready_o, which follow the IDLE grant rules below.

IDLE grant:
- Only IDLE grants; throughput is one operation per 2 cycles.
- Ack wins if ack_valid_i and (!miss_valid_i or streak < ACK_STREAK_MAX). Otherwise miss wins if miss_valid_i.
- Streak counter (4 bits):
  - +1 on each ack grant while miss_valid_i is high, saturating.
  - Cleared on a miss grant or when miss_valid_i is low.

Miss grant (in IDLE):
- miss_ready_o = 1.
- mshr_check_o = 1; mshr_check_set_o is taken from miss_nline_i.
- Latch all miss fields.
- Next state: CHK_WAIT.

Set/tag split:
- set = nline[MSHR_SET_WIDTH-1:0]; tag = next MSHR_TAG_WIDTH bits.
- With HPDCACHE_MSHR_SETS == 1: set = 0, tag = nline low bits.

CHK_WAIT:
- mshr_check_tag_o is driven from the latch; mshr_hit_i and mshr_alloc_full_i are evaluated.
- Hit: status HIT.
- Else if full: status FULL.
- Else: mshr_alloc_o = mshr_alloc_cs_o = 1 with the latched fields; miss_rsp_way_o = mshr_alloc_way_i; status ALLOC.
- miss_rsp_valid_o = 1 in every case. Next state: IDLE.
- Hit takes precedence over full.

Ack grant (in IDLE):
- ack_ready_o = 1.
- mshr_ack_o = mshr_ack_cs_o = 1 with ack_set_i and ack_way_i.
- Next state: ACK_WAIT.

ACK_WAIT:
- ack_rsp_valid_o = 1 for one cycle. The requester samples the MSHR ack_* outputs in this cycle.
- Next state: IDLE.

Port-exclusivity rules:
- Ack and check/alloc are never asserted together.
- Check and alloc are never asserted in the same cycle.
- At most one ready signal is high per cycle.

Response and other rules:
- Responses have no backpressure.
- Miss latency: accept cycle N → miss_rsp_valid_o at N+1.
- Ack latency: accept cycle N → ack_rsp_valid_o at N+1.
- A request valid raised in CHK_WAIT or ACK_WAIT waits for IDLE.
- Reset during CHK_WAIT: no alloc and no response are issued; the request is lost. The requester must reissue.

Assertions:
- Never both readies high in the same cycle.
- Never mshr_ack_o together with mshr_check_o or mshr_alloc_o.

Test Plan:
- Empty MSHR; miss on nline 0x1234 at cycle 0 → check at 0; alloc at 1 with way 0; rsp ALLOC, way 0 at 1.
- Repeat the same nline → rsp HIT at +1; no alloc pulse.
- Fill every way of the target set, then miss to that set → rsp FULL; mshr_alloc_o stays 0.
- miss_valid and ack_valid held high continuously, ACK_STREAK_MAX = 4 → grant order ack×4, miss, ack×4; streak counter resets after each miss grant.
- Ack set 2, way 1 after allocating it → ack pulse at N; ack_rsp_valid at N+1 with the original req_id/nline; the entry is then free (re-allocation of that set returns way 1).
- rst_i asserted in CHK_WAIT → next cycle IDLE; no alloc and no rsp; all outputs 0.
